// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the stream_demux_n slice:
//   - state_t        : packet-tracking FSM states (IDLE, PKT)
//   - CNT_W_DEFAULT  : default width of the drop counter
//   - ch_offset()    : bit offset of channel k inside a flattened data bus
// ---------------------------------------------------------------------------
package demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  localparam int CNT_W_DEFAULT = 16;

  // Channel k occupies bits [k*data_w +: data_w] of the flattened bus.
  function automatic int ch_offset(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/demux_ch_reg.sv
// ---------------------------------------------------------------------------
// demux_ch_reg
// Single-channel output register of the demux. Holds one beat until the
// downstream consumer takes it, then returns to zero data / zero last.
//
// Ports:
//   clk          in   system clock, rising edge
//   rstn         in   asynchronous active-low reset
//   load         in   write load_data/load_last into the register this cycle
//   load_data    in   DATA_W sample to store
//   load_last    in   last flag to store
//   drain_ready  in   downstream ready for this channel
//   data         out  DATA_W registered sample (zero when empty)
//   valid        out  registered valid
//   last         out  registered last (zero when empty)
// ---------------------------------------------------------------------------
module demux_ch_reg #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              drain_ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              last
);

  // A load takes priority over a drain so that a beat leaving and a new beat
  // arriving in the same cycle keeps the channel full (one beat per cycle).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
      last  <= load_last;
    end else if (valid && drain_ready) begin
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_n.sv
// ---------------------------------------------------------------------------
// stream_demux_n
// Registered 1:N demultiplexer for ADC sample streams. The destination
// channel is taken from in_sel on the first beat of a packet and held until
// the beat carrying in_last. Packets for a non-existent channel are accepted,
// discarded and counted in a saturating drop counter.
//
// Ports:
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset
//   in_data    in   DATA_W input sample
//   in_sel     in   SEL_W destination channel (first beat only)
//   in_valid   in   input beat valid
//   in_last    in   final beat of packet
//   in_ready   out  input may transfer this cycle
//   out_data   out  N_CH*DATA_W, channel k at [k*DATA_W +: DATA_W]
//   out_valid  out  N_CH per-channel valid
//   out_last   out  N_CH per-channel last
//   out_ready  in   N_CH per-channel ready
//   busy       out  packet in progress
//   drop_cnt   out  CNT_W saturating count of dropped packets
// ---------------------------------------------------------------------------
module stream_demux_n
  import demux_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int N_CH   = 4,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [N_CH-1:0]        out_valid,
  output logic [N_CH-1:0]        out_last,
  input  logic [N_CH-1:0]        out_ready,
  output logic                   busy,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam logic [SEL_W:0] N_CH_EXT = (SEL_W + 1)'(N_CH);

  state_t            state;
  logic [SEL_W-1:0]  locked_ch;
  logic [SEL_W-1:0]  ch;
  logic              drop;
  logic              ch_blocked;
  logic              in_xfer;
  logic [N_CH-1:0]   load;

  // The channel is only taken from in_sel at the start of a packet; during a
  // packet the latched value is used so in_sel may change freely.
  assign ch   = (state == PKT) ? locked_ch : in_sel;
  assign drop = ({1'b0, ch} >= N_CH_EXT);

  // Only the addressed channel can stall the input. A loop compare is used
  // instead of indexing with ch so out-of-range channels simply match nothing.
  always_comb begin
    ch_blocked = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch == SEL_W'(k)) begin
        ch_blocked = out_valid[k] && !out_ready[k];
      end
    end
  end

  assign in_ready = rstn && (drop || !ch_blocked);
  assign in_xfer  = in_valid && in_ready;
  assign busy     = (state == PKT);

  // One-hot load strobe; a dropped channel matches no k so nothing is loaded.
  always_comb begin
    load = '0;
    for (int k = 0; k < N_CH; k++) begin
      load[k] = in_xfer && (ch == SEL_W'(k));
    end
  end

  // Packet tracking, channel latch and drop counting. The drop counter only
  // moves on the first beat of a packet (IDLE), never on continuation beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      locked_ch <= '0;
      drop_cnt  <= '0;
    end else if (in_xfer) begin
      case (state)
        IDLE: begin
          if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
          end
          if (!in_last) begin
            locked_ch <= in_sel;
            state     <= PKT;
          end
        end
        PKT: begin
          if (in_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    demux_ch_reg #(
      .DATA_W(DATA_W)
    ) u_reg (
      .clk        (clk),
      .rstn       (rstn),
      .load       (load[k]),
      .load_data  (in_data),
      .load_last  (in_last),
      .drain_ready(out_ready[k]),
      .data       (out_data[ch_offset(k, DATA_W) +: DATA_W]),
      .valid      (out_valid[k]),
      .last       (out_last[k])
    );
  end

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Registered, parametrised 1:N demultiplexer for ADC sample streams, replacing the combinational 1:2 data demux.
- Routes a valid/ready input stream to one of N_CH output channels, chosen per packet. The channel is latched on the first beat of a packet and held until the beat carrying in_last.
- Non-selected outputs carry zero data. Packets addressed to a non-existent channel are consumed and counted as drops.
- Sits between the ADC capture path and the per-channel trigger/FIFO logic.

Parameters:
- DATA_W, 12, width of one sample word
- N_CH, 4, number of output channels (2..16)
- SEL_W, 4, width of in_sel; must satisfy 2**SEL_W >= N_CH
- CNT_W, 16, width of the drop counter

Ports:
- clk  in  1  system clock; all logic rising-edge
- rstn  in  1  asynchronous active-low reset
- in_data  in  DATA_W  input sample
- in_sel  in  SEL_W  destination channel; sampled only on the first beat of a packet
- in_valid  in  1  input beat valid
- in_last  in  1  final beat of packet
- in_ready  out  1  input may transfer this cycle
- out_data  out  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- out_valid  out  N_CH  per-channel valid
- out_last  out  N_CH  per-channel last
- out_ready  in  N_CH  per-channel ready
- busy  out  1  high while a packet is in progress (state PKT)
- drop_cnt  out  CNT_W  saturating count of dropped packets

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, locked channel=0, all out_valid/out_last=0, all out_data=0, drop_cnt=0, busy=0. in_ready is 0 while rstn is low.
- Transfer definitions:
  - Input transfer: in_valid && in_ready on a rising clk edge.
  - Output transfer on channel k: out_valid[k] && out_ready[k].
- Effective channel:
  - ch = in_sel in IDLE; ch = locked channel in PKT.
  - drop = (ch >= N_CH).
- in_ready (combinational):
  - drop: 1.
  - Otherwise: !out_valid[ch] || out_ready[ch].
  - No combinational path from in_valid to in_ready.
- State machine:
  - IDLE: input transfer with in_last=0 → latch in_sel, go to PKT. With in_last=1 (single-beat packet) → stay IDLE.
  - PKT: input transfer with in_last=1 → IDLE. Otherwise stay in PKT. in_sel is ignored in PKT.
- Datapath (one output register per channel, latency exactly 1 cycle):
  - Input transfer, not drop: out_data[ch] <= in_data, out_last[ch] <= in_last, out_valid[ch] <= 1.
  - Output transfer on channel k with no new load into k: out_valid[k] <= 0, out_data[k] <= 0, out_last[k] <= 0.
  - Simultaneous drain and load on the same channel: the load wins; out_valid stays 1 and the new data appears next cycle (full throughput, 1 beat/cycle).
  - Channels other than ch are unaffected by input transfers; each drains independently.
- Drop:
  - A packet is dropped when ch >= N_CH at its first beat; all of its beats are accepted and discarded.
  - drop_cnt increments by 1 on the first beat of each dropped packet and saturates at all-ones (no wrap).
- Back-pressure: with out_ready[ch]=0 and out_valid[ch]=1, in_ready=0; the input must hold. Other channels' out_ready have no effect on the input.
- Reset mid-packet returns to IDLE immediately. Any partially delivered packet is abandoned; downstream sees no out_last for it.
- busy = (state == PKT).

Decomposition:
- Shared package demux_pkg: state encoding (IDLE, PKT), CNT_W default, helper function for the channel bit-slice offset k*DATA_W.
- One natural sub-module, demux_ch_reg: a single-channel output register with load/drain/zeroing. Instantiate it N_CH times in a generate loop.
- The top level holds the FSM, the channel latch, in_ready and drop_cnt.

Test Plan:
- Reset: assert rstn=0 mid-stream → all out_valid=0, out_data=0, drop_cnt=0, busy=0 asynchronously. After release, the first beat with in_sel=2 routes to channel 2.
- Packet lock: 4-beat packet, in_sel=1 on beat 0, in_sel changed to 3 on beats 1-3, data 0x101..0x104 → all four beats appear on channel 1 one cycle after each transfer. out_last[1]=1 only with 0x104. Channel 3 stays zero/invalid.
- Throughput: out_ready all 1, continuous single-beat packets cycling sel 0,1,2,3 → in_ready stays 1, each channel shows its beat exactly one cycle later, 1 beat/cycle sustained.
- Back-pressure: channel 0 out_ready=0 with one beat held → in_ready=0 for further sel=0 beats; data 0x0AA held stable. Releasing out_ready for one cycle → next beat 0x0AB loads the same cycle, no bubble.
- Drop: N_CH=4, send a 3-beat packet with in_sel=7 → in_ready=1 on all beats, no out_valid asserted, drop_cnt 0→1. Repeat with CNT_W=2 for 5 packets → drop_cnt saturates at 3.
- Reset mid-packet: rstn pulsed low after beat 2 of a 5-beat sel=2 packet → busy=0, channel 2 cleared. The next packet with sel=0 is routed to channel 0 normally.
